// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: bus request/response,
// the fetch->decode payload, the fetch FSM states and the next-PC select.
package fetch_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] word_t;

    localparam addr_t RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        addr_t pc;
        word_t instruction;
    } fetch_data_t;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t;

    typedef enum logic [1:0] {PC_KEEP, PC_SEQ, PC_REDIRECT, PC_PEND} pc_sel_t;

endpackage

// File: rtl/fetch_pcsel.sv
// Next-PC selection for fetch: keep, sequential +4, redirect target or
// pending redirect target. Redirect targets are forced word-aligned.
module fetch_pcsel
    import fetch_pkg::*;
(
    input  pc_sel_t sel_i,
    input  addr_t   pc_i,
    input  addr_t   redirect_pc_i,
    input  addr_t   pend_pc_i,
    output addr_t   pc_o
);

    always_comb begin
        pc_o = pc_i;
        case (sel_i)
            PC_KEEP:     pc_o = pc_i;
            PC_SEQ:      pc_o = pc_i + 64'd4;
            PC_REDIRECT: pc_o = redirect_pc_i & ~64'h3;
            PC_PEND:     pc_o = pend_pc_i & ~64'h3;
            default:     pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one bus request in flight,
// hands instructions to decode over validF/readyD and squashes wrong-path fetches.
module fetch
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc,
    output logic        validF,
    input  logic        readyD,
    output fetch_data_t dataF,
    output logic [63:0] fetch_count
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         pend_q, pend_d;
    addr_t        pend_pc_q, pend_pc_d;
    logic         valid_q, valid_d;
    fetch_data_t  data_q, data_d;
    logic [63:0]  count_q, count_d;
    logic         req_valid_q, req_valid_d;
    addr_t        req_addr_q, req_addr_d;
    pc_sel_t      pc_sel;
    logic         accepted;
    logic         fire;

    fetch_pcsel u_pcsel (
        .sel_i         (pc_sel),
        .pc_i          (pc_q),
        .redirect_pc_i (redirect_pc),
        .pend_pc_i     (pend_pc_q),
        .pc_o          (pc_d)
    );

    assign accepted = req_valid_q & iresp.addr_ok;
    assign fire     = valid_q & readyD & ~redirect_valid;

    always_comb begin
        state_d   = state_q;
        pc_sel    = PC_KEEP;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        valid_d   = valid_q;
        data_d    = data_q;
        count_d   = count_q;
        case (state_q)
            REQ: begin
                if (accepted && iresp.data_ok) begin
                    if (redirect_valid) begin
                        pc_sel = PC_REDIRECT;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_sel = PC_PEND;
                        pend_d = 1'b0;
                    end else begin
                        data_d.pc          = pc_q;
                        data_d.instruction = iresp.data;
                        valid_d            = 1'b1;
                        state_d            = HOLD;
                    end
                end else if (accepted) begin
                    if (redirect_valid) begin
                        pc_sel  = PC_REDIRECT;
                        pend_d  = 1'b0;
                        state_d = DROP;
                    end else if (pend_q) begin
                        pc_sel  = PC_PEND;
                        pend_d  = 1'b0;
                        state_d = DROP;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (redirect_valid) begin
                    // A request already on the bus must stay stable, so park the target.
                    if (req_valid_q) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end else begin
                        pc_sel = PC_REDIRECT;
                    end
                end
            end
            WAIT: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        pc_sel  = PC_REDIRECT;
                        state_d = REQ;
                    end else begin
                        data_d.pc          = pc_q;
                        data_d.instruction = iresp.data;
                        valid_d            = 1'b1;
                        state_d            = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_sel  = PC_REDIRECT;
                    state_d = REQ;
                end else if (fire) begin
                    valid_d = 1'b0;
                    pc_sel  = PC_SEQ;
                    count_d = count_q + 64'd1;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_sel = PC_REDIRECT;
                end
                if (iresp.data_ok) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        req_valid_d = (state_d == REQ);
        req_addr_d  = (state_d == REQ) ? pc_d : req_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            count_q     <= count_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    assign ireq.valid  = req_valid_q;
    assign ireq.addr   = req_addr_q;
    assign validF      = valid_q;
    assign dataF       = data_q;
    assign fetch_count = count_q;

endmodule
